// File: rtl/gberet_rom_loader.sv
// ROM download feeder for the Green Beret core: filters the HPS byte stream,
// queues it in a 2-entry FIFO and replays each byte as a paced ROM write.
module gberet_rom_loader #(
    parameter int          ROM_BYTES = 196608,
    parameter int          HOLD      = 4,
    parameter logic [7:0]  INDEX     = 8'd0
) (
    input  logic        clk48M,
    input  logic        reset,
    input  logic        dl_active,
    input  logic [7:0]  dl_index,
    input  logic [24:0] dl_addr,
    input  logic [7:0]  dl_data,
    input  logic        dl_wr,
    output logic        dl_wait,
    output logic [17:0] ROMAD,
    output logic [7:0]  ROMDT,
    output logic        ROMEN,
    output logic        core_hold,
    output logic        load_done,
    output logic [7:0]  checksum,
    output logic [15:0] reject_cnt
);

    localparam logic [1:0]  S_IDLE  = 2'd0;
    localparam logic [1:0]  S_LOAD  = 2'd1;
    localparam logic [1:0]  S_DRAIN = 2'd2;
    localparam logic [1:0]  S_DONE  = 2'd3;
    localparam logic [24:0] ADDR_LIMIT = 25'(ROM_BYTES);
    localparam logic [3:0]  HOLD_LAST  = 4'(HOLD - 1);

    logic [1:0]  state_q, state_d;
    logic [25:0] fifo_mem_q [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;
    logic [3:0]  hold_cnt_q, hold_cnt_d;
    logic        romen_q, romen_d;
    logic [17:0] romad_q, romad_d;
    logic [7:0]  romdt_q, romdt_d;
    logic [7:0]  checksum_q, checksum_d;
    logic [15:0] reject_q, reject_d;

    logic        sel, strobe_ok, in_range, fifo_full, push, reject, pop, stats_clear;
    logic [25:0] head;
    logic [7:0]  checksum_base;
    logic [15:0] reject_base;

    // Strobes only count while idle or loading; drain and done ignore the host.
    always_comb begin
        sel         = dl_active && (dl_index == INDEX);
        strobe_ok   = dl_wr && sel && ((state_q == S_IDLE) || (state_q == S_LOAD));
        in_range    = dl_addr < ADDR_LIMIT;
        fifo_full   = (count_q == 2'd2);
        push        = strobe_ok && in_range && !fifo_full;
        reject      = strobe_ok && !push;
        pop         = !romen_q && (count_q != 2'd0);
        stats_clear = (state_q == S_IDLE) && sel;
        head        = fifo_mem_q[rd_ptr_q];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (sel) state_d = S_LOAD;
            S_LOAD:  if (!dl_active) state_d = S_DRAIN;
            S_DRAIN: if ((count_q == 2'd0) && !romen_q) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = pop  ? ~rd_ptr_q : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // A pop starts a burst; the cycle after the last high cycle is the mandatory gap.
    always_comb begin
        romen_d    = romen_q;
        hold_cnt_d = hold_cnt_q;
        romad_d    = romad_q;
        romdt_d    = romdt_q;
        if (pop) begin
            romen_d    = 1'b1;
            hold_cnt_d = 4'd0;
            romad_d    = head[25:8];
            romdt_d    = head[7:0];
        end else if (romen_q) begin
            if (hold_cnt_q == HOLD_LAST) begin
                romen_d    = 1'b0;
                hold_cnt_d = 4'd0;
            end else begin
                hold_cnt_d = hold_cnt_q + 4'd1;
            end
        end
    end

    always_comb begin
        checksum_base = stats_clear ? 8'd0 : checksum_q;
        reject_base   = stats_clear ? 16'd0 : reject_q;
        checksum_d    = pop ? checksum_base + head[7:0] : checksum_base;
        reject_d      = (reject && (reject_base != 16'hFFFF)) ? reject_base + 16'd1 : reject_base;
    end

    always_ff @(posedge clk48M or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            hold_cnt_q <= 4'd0;
            romen_q    <= 1'b0;
            romad_q    <= 18'd0;
            romdt_q    <= 8'd0;
            checksum_q <= 8'd0;
            reject_q   <= 16'd0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            hold_cnt_q <= hold_cnt_d;
            romen_q    <= romen_d;
            romad_q    <= romad_d;
            romdt_q    <= romdt_d;
            checksum_q <= checksum_d;
            reject_q   <= reject_d;
        end
    end

    // Storage needs no reset: an empty count makes stale entries unreachable.
    always_ff @(posedge clk48M) begin
        if (push) fifo_mem_q[wr_ptr_q] <= {dl_addr[17:0], dl_data};
    end

    assign dl_wait    = fifo_full;
    assign ROMAD      = romad_q;
    assign ROMDT      = romdt_q;
    assign ROMEN      = romen_q;
    assign core_hold  = (state_q != S_IDLE);
    assign load_done  = (state_q == S_DONE);
    assign checksum   = checksum_q;
    assign reject_cnt = reject_q;

endmodule

// File: tb/tb_gberet_rom_loader.sv
// Directed scenarios for gberet_rom_loader with hand-computed expectations;
// a negedge monitor records every ROMEN burst for the tasks to inspect.
module tb_gberet_rom_loader;

    logic        clk48M = 1'b0;
    logic        reset = 1'b1;
    logic        dl_active = 1'b0;
    logic [7:0]  dl_index = 8'd0;
    logic [24:0] dl_addr = 25'd0;
    logic [7:0]  dl_data = 8'd0;
    logic        dl_wr = 1'b0;
    logic        dl_wait;
    logic [17:0] ROMAD;
    logic [7:0]  ROMDT;
    logic        ROMEN;
    logic        core_hold;
    logic        load_done;
    logic [7:0]  checksum;
    logic [15:0] reject_cnt;

    int checks = 0;
    int failures = 0;

    gberet_rom_loader #(.ROM_BYTES(196608), .HOLD(4), .INDEX(8'd0)) dut (
        .clk48M(clk48M), .reset(reset), .dl_active(dl_active), .dl_index(dl_index),
        .dl_addr(dl_addr), .dl_data(dl_data), .dl_wr(dl_wr), .dl_wait(dl_wait),
        .ROMAD(ROMAD), .ROMDT(ROMDT), .ROMEN(ROMEN), .core_hold(core_hold),
        .load_done(load_done), .checksum(checksum), .reject_cnt(reject_cnt)
    );

    always #10 clk48M = ~clk48M;

    logic [17:0] burstAddr [$];
    logic [7:0]  burstData [$];
    int          burstStart [$];
    int          burstLen [$];
    int          cycleNo = 0;
    int          runLen = 0;
    int          doneCount = 0;
    logic        romenPrev = 1'b0;

    // Burst recorder: start cycle, address, data and high-cycle length of each ROMEN pulse.
    always @(negedge clk48M) begin
        cycleNo++;
        if (ROMEN && !romenPrev) begin
            burstAddr.push_back(ROMAD);
            burstData.push_back(ROMDT);
            burstStart.push_back(cycleNo);
            runLen = 1;
        end else if (ROMEN) begin
            runLen++;
        end
        if (!ROMEN && romenPrev) burstLen.push_back(runLen);
        romenPrev = ROMEN;
        if (load_done) doneCount++;
    end

    task automatic tick();
        @(posedge clk48M);
        #1;
    endtask

    task automatic strobe(input logic [24:0] a, input logic [7:0] d);
        dl_addr = a;
        dl_data = d;
        dl_wr   = 1'b1;
        tick();
        dl_wr   = 1'b0;
    endtask

    task automatic waitDone(input int limit, output int cycles, output bit holdOk);
        cycles = 0;
        holdOk = 1'b1;
        while (!load_done && cycles < limit) begin
            if (!core_hold) holdOk = 1'b0;
            tick();
            cycles++;
        end
        checks++;
        if (load_done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL done_timeout: load_done=%0b after %0d cycles, want 1", load_done, cycles);
        end
    endtask

    task automatic checkBurst(input string name, input int idx, input logic [17:0] a,
                              input logic [7:0] d);
        checks++;
        if (idx >= burstLen.size()) begin
            failures++;
            $display("[TB] FAIL %s[%0d]: burst missing, have %0d want index %0d", name, idx,
                     burstLen.size(), idx);
        end else if (burstAddr[idx] !== a || burstData[idx] !== d || burstLen[idx] != 4) begin
            failures++;
            $display("[TB] FAIL %s[%0d]: got addr=%h data=%h len=%0d want addr=%h data=%h len=4",
                     name, idx, burstAddr[idx], burstData[idx], burstLen[idx], a, d);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if ({ROMEN, core_hold, load_done, dl_wait, ROMAD, ROMDT, checksum, reject_cnt} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got en=%b hold=%b done=%b wait=%b ad=%h dt=%h cs=%h rej=%h want all 0",
                     ROMEN, core_hold, load_done, dl_wait, ROMAD, ROMDT, checksum, reject_cnt);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_sequential();
        int  base = burstLen.size();
        int  d0 = doneCount;
        int  cyc;
        bit  holdOk;
        dl_index  = 8'd0;
        dl_active = 1'b1;
        tick();
        checks++;
        if (core_hold !== 1'b1) begin
            failures++;
            $display("[TB] FAIL seq_hold_on: got %b want 1", core_hold);
        end
        for (int i = 0; i < 16; i++) begin
            strobe(25'(i), 8'(i + 1));
            repeat (7) tick();
        end
        dl_active = 1'b0;
        waitDone(200, cyc, holdOk);
        tick();
        checks++;
        if (core_hold !== 1'b0) begin
            failures++;
            $display("[TB] FAIL seq_hold_off: got %b want 0", core_hold);
        end
        repeat (3) tick();
        checks++;
        if (burstLen.size() - base != 16) begin
            failures++;
            $display("[TB] FAIL seq_count: got %0d bursts want 16", burstLen.size() - base);
        end
        for (int i = 0; i < 16; i++) checkBurst("seq_burst", base + i, 18'(i), 8'(i + 1));
        checks++;
        if (checksum !== 8'd136 || reject_cnt !== 16'd0) begin
            failures++;
            $display("[TB] FAIL seq_stats: got cs=%0d rej=%0d want cs=136 rej=0", checksum, reject_cnt);
        end
        checks++;
        if (doneCount - d0 != 1) begin
            failures++;
            $display("[TB] FAIL seq_done_pulses: got %0d want 1", doneCount - d0);
        end
    endtask

    task automatic test_wrong_index();
        int base = burstLen.size();
        int d0 = doneCount;
        int holdSeen = 0;
        dl_index  = 8'd1;
        dl_active = 1'b1;
        for (int i = 0; i < 10; i++) begin
            strobe(25'(i), 8'(i + 8'h30));
            if (core_hold) holdSeen++;
            tick();
            if (core_hold) holdSeen++;
        end
        dl_active = 1'b0;
        repeat (8) tick();
        dl_index = 8'd0;
        checks++;
        if (holdSeen != 0 || burstStart.size() != base || doneCount != d0) begin
            failures++;
            $display("[TB] FAIL wrong_index: got holdCycles=%0d bursts=%0d dones=%0d want 0 0 0",
                     holdSeen, burstStart.size() - base, doneCount - d0);
        end
        checks++;
        if (reject_cnt !== 16'd0 || checksum !== 8'd136) begin
            failures++;
            $display("[TB] FAIL wrong_index_stats: got rej=%0d cs=%0d want rej=0 cs=136", reject_cnt, checksum);
        end
    endtask

    task automatic test_backpressure();
        int  base = burstLen.size();
        int  sent = 0;
        int  guard = 0;
        int  cyc;
        bit  holdOk;
        bit  sawWait = 1'b0;
        dl_active = 1'b1;
        tick();
        while (sent < 6 && guard < 200) begin
            guard++;
            if (dl_wait) begin
                sawWait = 1'b1;
                tick();
            end else begin
                strobe(25'(100 + sent), 8'(8'hA0 + sent));
                sent++;
            end
        end
        dl_active = 1'b0;
        waitDone(200, cyc, holdOk);
        repeat (3) tick();
        checks++;
        if (!sawWait || sent != 6) begin
            failures++;
            $display("[TB] FAIL bp_wait: got sawWait=%b sent=%0d want 1 6", sawWait, sent);
        end
        checks++;
        if (burstLen.size() - base != 6) begin
            failures++;
            $display("[TB] FAIL bp_count: got %0d bursts want 6", burstLen.size() - base);
        end
        for (int i = 0; i < 6; i++) checkBurst("bp_burst", base + i, 18'(100 + i), 8'(8'hA0 + i));
        for (int i = 1; i < 6; i++) begin
            if (base + i < burstStart.size()) begin
                checks++;
                if (burstStart[base + i] - burstStart[base + i - 1] != 5) begin
                    failures++;
                    $display("[TB] FAIL bp_spacing[%0d]: got %0d cycles want 5", i,
                             burstStart[base + i] - burstStart[base + i - 1]);
                end
            end
        end
        checks++;
        if (checksum !== 8'd207) begin
            failures++;
            $display("[TB] FAIL bp_checksum: got %0d want 207", checksum);
        end
    endtask

    task automatic test_range();
        int base = burstLen.size();
        int cyc;
        bit holdOk;
        dl_active = 1'b1;
        tick();
        strobe(25'd196607, 8'h5A);
        strobe(25'd196608, 8'h77);
        dl_active = 1'b0;
        waitDone(100, cyc, holdOk);
        repeat (3) tick();
        checks++;
        if (burstLen.size() - base != 1) begin
            failures++;
            $display("[TB] FAIL range_count: got %0d bursts want 1", burstLen.size() - base);
        end
        checkBurst("range_burst", base, 18'h2FFFF, 8'h5A);
        checks++;
        if (reject_cnt !== 16'd1 || checksum !== 8'h5A) begin
            failures++;
            $display("[TB] FAIL range_stats: got rej=%0d cs=%h want rej=1 cs=5a", reject_cnt, checksum);
        end
    endtask

    task automatic test_drain();
        int base = burstLen.size();
        int d0 = doneCount;
        int cyc;
        bit holdOk;
        dl_active = 1'b1;
        tick();
        strobe(25'd200, 8'h11);
        strobe(25'd201, 8'h22);
        strobe(25'd202, 8'h33);
        checks++;
        if (dl_wait !== 1'b1) begin
            failures++;
            $display("[TB] FAIL drain_wait: got %b want 1", dl_wait);
        end
        dl_active = 1'b0;
        waitDone(100, cyc, holdOk);
        checks++;
        if (!holdOk || core_hold !== 1'b1) begin
            failures++;
            $display("[TB] FAIL drain_hold: got holdOk=%b hold=%b want 1 1", holdOk, core_hold);
        end
        tick();
        checks++;
        if (core_hold !== 1'b0) begin
            failures++;
            $display("[TB] FAIL drain_hold_off: got %b want 0", core_hold);
        end
        repeat (3) tick();
        checkBurst("drain_burst", base, 18'd200, 8'h11);
        checkBurst("drain_burst", base + 1, 18'd201, 8'h22);
        checkBurst("drain_burst", base + 2, 18'd202, 8'h33);
        checks++;
        if (checksum !== 8'h66 || doneCount - d0 != 1) begin
            failures++;
            $display("[TB] FAIL drain_stats: got cs=%h dones=%0d want cs=66 dones=1", checksum, doneCount - d0);
        end
    endtask

    task automatic test_reset_midburst();
        int base;
        int cyc;
        bit holdOk;
        dl_active = 1'b1;
        tick();
        strobe(25'd300, 8'h44);
        strobe(25'd301, 8'h55);
        strobe(25'd302, 8'h66);
        checks++;
        if (ROMEN !== 1'b1 || ROMAD !== 18'd300) begin
            failures++;
            $display("[TB] FAIL mid_burst_active: got en=%b ad=%0d want 1 300", ROMEN, ROMAD);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({ROMEN, core_hold, load_done, dl_wait, ROMAD, ROMDT, checksum, reject_cnt} !== '0) begin
            failures++;
            $display("[TB] FAIL mid_reset_outputs: got en=%b hold=%b done=%b wait=%b ad=%h dt=%h cs=%h rej=%h want all 0",
                     ROMEN, core_hold, load_done, dl_wait, ROMAD, ROMDT, checksum, reject_cnt);
        end
        dl_active = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        repeat (2) tick();
        base = burstStart.size();
        repeat (10) tick();
        checks++;
        if (burstStart.size() != base) begin
            failures++;
            $display("[TB] FAIL mid_fifo_flush: got %0d stale bursts want 0", burstStart.size() - base);
        end
        base = burstLen.size();
        dl_active = 1'b1;
        tick();
        strobe(25'd200000, 8'hEE);
        strobe(25'd5, 8'h09);
        dl_active = 1'b0;
        waitDone(100, cyc, holdOk);
        repeat (3) tick();
        checkBurst("post_reset_burst", base, 18'd5, 8'h09);
        checks++;
        if (reject_cnt !== 16'd1 || checksum !== 8'h09) begin
            failures++;
            $display("[TB] FAIL post_reset_stats: got rej=%0d cs=%h want rej=1 cs=09", reject_cnt, checksum);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_wrong_index();
        test_backpressure();
        test_range();
        test_drain();
        test_reset_midburst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
